// File: rtl/proc_pkg.sv
// Shared processor definitions: status byte bit positions and its packed layout.
// Imported by the processor datapath and by the result capture FIFO.
package proc_pkg;

    localparam int ST_INT_EN = 0;
    localparam int ST_ZERO   = 1;
    localparam int ST_CARRY  = 2;
    localparam int ST_NEG    = 3;
    localparam int ST_PAR_LO = 4;
    localparam int ST_PAR_HI = 5;

    // Field order matches the bit positions above (MSB first in a packed struct).
    typedef struct packed {
        logic [1:0] reserved;  // [7:6] carried through untouched
        logic [1:0] parity;    // [5:4]
        logic       neg;       // [3]
        logic       carry;     // [2]
        logic       zero;      // [1]
        logic       int_en;    // [0]
    } proc_status_t;

    // Reinterpret a raw status byte as the structured view.
    function automatic proc_status_t to_status(input logic [7:0] raw);
        return proc_status_t'(raw);
    endfunction

endpackage

// File: rtl/proc_result_fifo.sv
// Result capture FIFO: buffers {status, data} words from the processor for a
// slower consumer, first-word fall-through, with sticky irq and overflow flags.
module proc_result_fifo
    import proc_pkg::*;
#(
    parameter  int DEPTH = 4,
    parameter  int DW    = 32,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rstN,
    input  logic          in_valid,
    input  logic [DW-1:0] data_in,
    input  logic [7:0]    status_in,
    output logic          in_ready,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] data_out,
    output logic [7:0]    status_out,
    output logic [CW-1:0] count,
    output logic          irq,
    input  logic          irq_ack,
    output logic          overflow,
    input  logic          ovf_clear
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        proc_status_t  status;
        logic [DW-1:0] data;
    } entry_t;

    entry_t       mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    logic push;
    logic pop;
    logic drop;
    entry_t head;
    proc_status_t st_in;

    assign st_in = to_status(status_in);

    // Ready/valid come only from registered occupancy, so no input reaches an output.
    // A full FIFO refuses input even when a pop happens in the same cycle.
    assign in_ready  = (count != CW'(DEPTH));
    assign out_valid = (count != '0);

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;
    assign drop = in_valid && !in_ready;

    // Fall-through head read; masked to zero while empty so stale memory never leaks out.
    always_comb begin
        head       = mem[rd_ptr];
        data_out   = '0;
        status_out = '0;
        if (out_valid) begin
            data_out   = head.data;
            status_out = head.status;
        end
    end

    // Storage array is not reset; writes are suppressed during the reset cycle.
    always_ff @(posedge clk) begin
        if (rstN && push) begin
            mem[wr_ptr] <= '{status: st_in, data: data_in};
        end
    end

    // Pointers and occupancy; power-of-two depth lets the pointers wrap by overflow.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    // Sticky interrupt: a buffered int_en result sets it, set beats a same-cycle ack.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            irq <= 1'b0;
        end else if (push && st_in.int_en) begin
            irq <= 1'b1;
        end else if (irq_ack) begin
            irq <= 1'b0;
        end
    end

    // Sticky overflow: a dropped word sets it, set beats a same-cycle clear.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (ovf_clear) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_proc_result_fifo.sv
// Bench for proc_result_fifo: directed scenarios plus randomized traffic,
// all checked against a queue-based reference model after every clock.
module tb_proc_result_fifo;

    localparam int DEPTH = 4;
    localparam int DW    = 32;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rstN;
    logic          in_valid;
    logic [DW-1:0] data_in;
    logic [7:0]    status_in;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] data_out;
    logic [7:0]    status_out;
    logic [CW-1:0] count;
    logic          irq;
    logic          irq_ack;
    logic          overflow;
    logic          ovf_clear;

    proc_result_fifo #(.DEPTH(DEPTH), .DW(DW)) dut (
        .clk        (clk),
        .rstN       (rstN),
        .in_valid   (in_valid),
        .data_in    (data_in),
        .status_in  (status_in),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .data_out   (data_out),
        .status_out (status_out),
        .count      (count),
        .irq        (irq),
        .irq_ack    (irq_ack),
        .overflow   (overflow),
        .ovf_clear  (ovf_clear)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: a plain queue of {status, data} plus the two sticky flags.
    logic [39:0] m_q [$];
    logic        m_irq = 1'b0;
    logic        m_ovf = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [39:0] h;
        h = (m_q.size() > 0) ? m_q[0] : 40'h0;
        chk("count",      64'(count),      64'(m_q.size()));
        chk("out_valid",  64'(out_valid),  64'(m_q.size() != 0));
        chk("in_ready",   64'(in_ready),   64'(m_q.size() < DEPTH));
        chk("data_out",   64'(data_out),   64'(h[31:0]));
        chk("status_out", 64'(status_out), 64'(h[39:32]));
        chk("irq",        64'(irq),        64'(m_irq));
        chk("overflow",   64'(overflow),   64'(m_ovf));
    endtask

    // Advance one clock: predict from the inputs currently driven, then compare.
    task automatic step();
        int  sz;
        bit  rst, do_push, do_drop, do_pop;
        bit  nxt_irq, nxt_ovf;
        logic [39:0] w;
        sz      = m_q.size();
        rst     = (rstN == 1'b0);
        do_push = in_valid && (sz < DEPTH);
        do_drop = in_valid && (sz == DEPTH);
        do_pop  = out_ready && (sz > 0);
        w       = {status_in, data_in};
        nxt_irq = (do_push && status_in[0]) ? 1'b1 : (irq_ack ? 1'b0 : m_irq);
        nxt_ovf = do_drop ? 1'b1 : (ovf_clear ? 1'b0 : m_ovf);
        @(posedge clk);
        #1;
        if (rst) begin
            m_q.delete();
            m_irq = 1'b0;
            m_ovf = 1'b0;
        end else begin
            if (do_pop)  void'(m_q.pop_front());
            if (do_push) m_q.push_back(w);
            m_irq = nxt_irq;
            m_ovf = nxt_ovf;
        end
        check_all();
    endtask

    task automatic idle();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        irq_ack   = 1'b0;
        ovf_clear = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] d, input logic [7:0] s);
        in_valid  = 1'b1;
        data_in   = d;
        status_in = s;
    endtask

    initial begin
        rstN = 1'b0;
        idle();
        data_in   = '0;
        status_in = '0;

        // Reset and empty behaviour
        step();
        rstN = 1'b1;
        step();
        chk("rst_count",    64'(count),    64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_data",     64'(data_out), 64'd0);
        out_ready = 1'b1;
        step();
        chk("empty_pop_count", 64'(count), 64'd0);
        idle();

        // FWFT order
        push_word(32'hDEADBEEF, 8'h00); step();
        push_word(32'hCAFEBABE, 8'h04); step();
        in_valid = 1'b0;
        chk("fwft_count", 64'(count),    64'd2);
        chk("fwft_head0", 64'(data_out), 64'hDEADBEEF);
        out_ready = 1'b1; step();
        chk("fwft_head1", 64'(data_out),   64'hCAFEBABE);
        chk("fwft_st1",   64'(status_out), 64'h04);
        step();
        chk("fwft_empty", 64'(out_valid), 64'd0);
        idle();

        // Full and overflow
        for (int i = 1; i <= 5; i++) begin
            push_word(32'(i), 8'h00);
            step();
        end
        in_valid = 1'b0;
        chk("full_count",    64'(count),    64'd4);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        chk("full_ovf",      64'(overflow), 64'd1);
        ovf_clear = 1'b1; step();
        ovf_clear = 1'b0;
        chk("ovf_cleared", 64'(overflow), 64'd0);
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("drain_order", 64'(data_out), 64'(i));
            step();
        end
        chk("drain_empty", 64'(out_valid), 64'd0);
        idle();

        // Wrap-around with simultaneous push and pop
        push_word(32'hA0, 8'hC0); step();
        for (int i = 1; i < 10; i++) begin
            push_word(32'hA0 + 32'(i), 8'hC0);
            out_ready = 1'b1;
            step();
            chk("wrap_count", 64'(count),    64'd1);
            chk("wrap_head",  64'(data_out), 64'hA0 + 64'(i));
        end
        in_valid = 1'b0; step();
        idle();

        // IRQ set, set-beats-ack, ack alone clears
        push_word(32'h11, 8'h05); step();
        chk("irq_set", 64'(irq), 64'd1);
        push_word(32'h22, 8'h01); irq_ack = 1'b1; step();
        chk("irq_set_wins", 64'(irq), 64'd1);
        in_valid = 1'b0; step();
        chk("irq_ack_clr", 64'(irq), 64'd0);
        idle();
        out_ready = 1'b1; step(); step();
        idle();

        // Reset mid-operation with flags set and a push pending
        for (int i = 0; i < 5; i++) begin
            push_word(32'h100 + 32'(i), 8'h01);
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1; step();
        out_ready = 1'b0;
        chk("pre_rst_count", 64'(count), 64'd3);
        push_word(32'h999, 8'h01);
        rstN = 1'b0; step();
        rstN = 1'b1; in_valid = 1'b0;
        chk("midrst_count", 64'(count),     64'd0);
        chk("midrst_valid", 64'(out_valid), 64'd0);
        chk("midrst_irq",   64'(irq),       64'd0);
        chk("midrst_ovf",   64'(overflow),  64'd0);
        step();

        // Randomized traffic with varying producer/consumer pressure
        for (int phase = 0; phase < 3; phase++) begin
            for (int c = 0; c < 400; c++) begin
                int pv, pr;
                pv = (phase == 0) ? 50 : (phase == 1) ? 85 : 30;
                pr = (phase == 0) ? 50 : (phase == 1) ? 30 : 85;
                in_valid  = ($urandom_range(99) < pv);
                out_ready = ($urandom_range(99) < pr);
                data_in   = $urandom;
                status_in = 8'($urandom);
                irq_ack   = ($urandom_range(9) == 0);
                ovf_clear = ($urandom_range(9) == 0);
                rstN      = ($urandom_range(199) != 0);
                step();
            end
        end
        rstN = 1'b1;
        idle();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
